// File: rtl/stream_protocol_checker_if.sv
// stream_protocol_checker_if: bundle of NCH valid/ready/data streams
//   ch_valid[NCH]   source asserts a beat
//   ch_ready[NCH]   sink accepts a beat
//   ch_data[NCH*W]  channel i occupies bits [i*W +: W]
//   master drives valid/data, slave drives ready, monitor only observes
interface stream_protocol_checker_if #(
   parameter int NCH = 4,
   parameter int W   = 8
);
   logic [NCH-1:0]   ch_valid;
   logic [NCH-1:0]   ch_ready;
   logic [NCH*W-1:0] ch_data;
   modport master  (output ch_valid, output ch_data, input ch_ready);
   modport slave   (input ch_valid, input ch_data, output ch_ready);
   modport monitor (input ch_valid, input ch_ready, input ch_data);
endinterface

// File: rtl/stream_protocol_checker.sv
// stream_protocol_checker: passive runtime monitor for NCH valid/ready streams
//   clk, rst      clock, synchronous active-high reset
//   en, clr       checking enable, synchronous clear of reported state
//   s             observed streams (monitor modport)
//   err_sticky    per channel {TIMEOUT, UNSTABLE, DROP}
//   err_count     saturating total of violations
//   first_*       capture of the first violation (channel, code)
//   irq           registered OR of err_sticky
module stream_protocol_checker #(
   parameter int NCH     = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 4,
   parameter int CW      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   stream_protocol_checker_if.monitor s,
   output logic [NCH*3-1:0]      err_sticky,
   output logic [CW-1:0]         err_count,
   output logic                  first_valid,
   output logic [3:0]            first_ch,
   output logic [1:0]            first_code,
   output logic                  irq
);
   localparam int SW = $clog2(TIMEOUT + 2);
   logic [NCH-1:0]   stalled_q;
   logic [NCH-1:0]   stall;
   logic [W-1:0]     snap [NCH];
   logic [SW-1:0]    stall_cnt [NCH];
   logic [NCH*3-1:0] viol;
   logic [CW+4:0]    sum;
   logic [3:0]       win_ch;
   logic [1:0]       win_code;
   // DROP needs valid low and UNSTABLE needs valid high, so they never coincide;
   // scanning from the top lets the lowest channel win the capture
   always_comb begin
      stall    = '0;
      viol     = '0;
      sum      = {5'd0, err_count};
      win_ch   = '0;
      win_code = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         stall[i]      = s.ch_valid[i] & ~s.ch_ready[i];
         viol[3*i]     = en & stalled_q[i] & ~s.ch_valid[i];
         viol[3*i+1]   = en & stalled_q[i] & s.ch_valid[i] & (s.ch_data[i*W +: W] != snap[i]);
         viol[3*i+2]   = en & stall[i] & (stall_cnt[i] == SW'(TIMEOUT));
         sum           = sum + (CW+5)'(viol[3*i]) + (CW+5)'(viol[3*i+1]) + (CW+5)'(viol[3*i+2]);
         if (|viol[3*i +: 3]) begin
            win_ch   = 4'(i);
            win_code = viol[3*i] ? 2'd1 : viol[3*i+1] ? 2'd2 : 2'd3;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         stalled_q   <= '0;
         err_sticky  <= '0;
         err_count   <= '0;
         first_valid <= 1'b0;
         first_ch    <= '0;
         first_code  <= '0;
         irq         <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            snap[i]      <= '0;
            stall_cnt[i] <= '0;
         end
      end else begin
         irq       <= |err_sticky;
         stalled_q <= en ? stall : '0;
         // counter parks at TIMEOUT+1 so TIMEOUT fires once per stall episode
         for (int i = 0; i < NCH; i++) begin
            if (en & stall[i]) snap[i] <= s.ch_data[i*W +: W];
            stall_cnt[i] <= !(en & stall[i]) ? '0 :
                            (stall_cnt[i] == SW'(TIMEOUT + 1)) ? stall_cnt[i] : stall_cnt[i] + SW'(1);
         end
         if (clr) begin
            err_sticky  <= '0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_ch    <= '0;
            first_code  <= '0;
         end else begin
            err_sticky <= err_sticky | viol;
            err_count  <= (sum > (CW+5)'({CW{1'b1}})) ? {CW{1'b1}} : sum[CW-1:0];
            if (!first_valid && |viol) begin
               first_valid <= 1'b1;
               first_ch    <= win_ch;
               first_code  <= win_code;
            end
         end
      end
   end
endmodule
